// File: rtl/alu_arbiter.sv
// alu_arbiter: two requesters share one 16-bit-operand / 32-bit-result ALU.
// Round-robin grant in IDLE, compute in EXEC, hold the response in RESP until it is accepted.
//
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_valid0/1                   per-requester operation pending
//   i_op1_x, i_op2_x, i_sel_x    operands and opcode per requester
//   o_ready0/1                   one-cycle grant pulse (operands captured)
//   o_resp_valid, i_resp_ready   response handshake
//   o_resp_id                    requester owning the response
//   o_result, o_zero, o_err      result, zero flag, illegal-opcode flag
//   o_busy                       block is not idle
module alu_arbiter (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid0,
  input  logic        i_valid1,
  input  logic [15:0] i_op1_0,
  input  logic [15:0] i_op2_0,
  input  logic [15:0] i_op1_1,
  input  logic [15:0] i_op2_1,
  input  logic [2:0]  i_sel0,
  input  logic [2:0]  i_sel1,
  output logic        o_ready0,
  output logic        o_ready1,
  output logic        o_resp_valid,
  input  logic        i_resp_ready,
  output logic        o_resp_id,
  output logic [31:0] o_result,
  output logic        o_zero,
  output logic        o_err,
  output logic        o_busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_NOP = 3'b100;

  logic [1:0]  state_q, state_d;
  logic        ptr_q, ptr_d;
  logic [15:0] op1_q, op1_d;
  logic [15:0] op2_q, op2_d;
  logic [2:0]  sel_q, sel_d;
  logic        id_q, id_d;
  logic [31:0] result_q, result_d;
  logic        zero_q, zero_d;
  logic        err_q, err_d;
  logic        rid_q, rid_d;

  logic        idle;
  logic        any_req;
  logic        win;
  logic        grant;

  logic [31:0] a32;
  logic [31:0] b32;
  logic [31:0] alu_res;
  logic        alu_ill;

  assign idle    = (state_q == S_IDLE);
  assign any_req = i_valid0 | i_valid1;

  // Both pending: pointer decides. One pending: that one wins.
  assign win = (i_valid0 & i_valid1) ? ptr_q : i_valid1;

  // Reset masks the grant so no operand is ever taken in a reset cycle.
  assign grant    = idle & any_req & ~i_rst;
  assign o_ready0 = grant & ~win;
  assign o_ready1 = grant & win;

  assign a32 = {16'd0, op1_q};
  assign b32 = {16'd0, op2_q};

  // NOP and illegal codes keep the previous result.
  always_comb begin
    alu_res = result_q;
    alu_ill = 1'b0;
    unique case (sel_q)
      OP_ADD:  alu_res = a32 + b32;
      OP_SUB:  alu_res = a32 - b32;
      OP_AND:  alu_res = a32 & b32;
      OP_OR:   alu_res = a32 | b32;
      OP_NOP:  alu_res = result_q;
      default: alu_ill = 1'b1;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    sel_d    = sel_q;
    id_d     = id_q;
    result_d = result_q;
    zero_d   = zero_q;
    err_d    = err_q;
    rid_d    = rid_q;
    unique case (state_q)
      S_IDLE: begin
        if (any_req) begin
          state_d = S_EXEC;
          ptr_d   = ~win;
          id_d    = win;
          op1_d   = win ? i_op1_1 : i_op1_0;
          op2_d   = win ? i_op2_1 : i_op2_0;
          sel_d   = win ? i_sel1  : i_sel0;
        end
      end
      S_EXEC: begin
        state_d  = S_RESP;
        result_d = alu_res;
        zero_d   = (alu_res == 32'd0);
        err_d    = alu_ill;
        rid_d    = id_q;
      end
      S_RESP: begin
        if (i_resp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      ptr_q    <= 1'b0;
      op1_q    <= 16'd0;
      op2_q    <= 16'd0;
      sel_q    <= OP_NOP;
      id_q     <= 1'b0;
      result_q <= 32'd0;
      zero_q   <= 1'b1;
      err_q    <= 1'b0;
      rid_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      sel_q    <= sel_d;
      id_q     <= id_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
      rid_q    <= rid_d;
    end
  end

  assign o_resp_valid = (state_q == S_RESP);
  assign o_busy       = ~idle;
  assign o_resp_id    = rid_q;
  assign o_result     = result_q;
  assign o_zero       = zero_q;
  assign o_err        = err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed + random transactions against a
// transaction-level model of the shared-ALU arbiter.
`timescale 1ns/1ps
module tb_alu_arbiter;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_valid0, i_valid1;
  logic [15:0] i_op1_0, i_op2_0, i_op1_1, i_op2_1;
  logic [2:0]  i_sel0, i_sel1;
  logic        o_ready0, o_ready1;
  logic        o_resp_valid;
  logic        i_resp_ready;
  logic        o_resp_id;
  logic [31:0] o_result;
  logic        o_zero, o_err, o_busy;

  always #5 i_clk = ~i_clk;

  logic        v [2];
  logic [15:0] a [2];
  logic [15:0] b [2];
  logic [2:0]  s [2];

  assign i_valid0 = v[0];
  assign i_valid1 = v[1];
  assign i_op1_0  = a[0];
  assign i_op2_0  = b[0];
  assign i_op1_1  = a[1];
  assign i_op2_1  = b[1];
  assign i_sel0   = s[0];
  assign i_sel1   = s[1];

  alu_arbiter dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_valid0     (i_valid0),
    .i_valid1     (i_valid1),
    .i_op1_0      (i_op1_0),
    .i_op2_0      (i_op2_0),
    .i_op1_1      (i_op1_1),
    .i_op2_1      (i_op2_1),
    .i_sel0       (i_sel0),
    .i_sel1       (i_sel1),
    .o_ready0     (o_ready0),
    .o_ready1     (o_ready1),
    .o_resp_valid (o_resp_valid),
    .i_resp_ready (i_resp_ready),
    .o_resp_id    (o_resp_id),
    .o_result     (o_result),
    .o_zero       (o_zero),
    .o_err        (o_err),
    .o_busy       (o_busy)
  );

  int          total = 0;
  int          bad   = 0;
  int          ptr   = 0;
  logic [31:0] last  = 32'd0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // {err, result}; operands zero-extended, arithmetic mod 2^32
  function automatic logic [32:0] ref_op(input logic [2:0] sel,
    input logic [15:0] x, input logic [15:0] y, input logic [31:0] prev);
    longint xl = longint'(x);
    longint yl = longint'(y);
    case (sel)
      3'd0:    return {1'b0, 32'(xl + yl)};
      3'd1:    return {1'b0, 32'(xl - yl)};
      3'd2:    return {1'b0, 16'd0, x & y};
      3'd3:    return {1'b0, 16'd0, x | y};
      3'd4:    return {1'b0, prev};
      default: return {1'b1, prev};
    endcase
  endfunction

  task automatic req(input int r, input logic [2:0] sel,
                     input logic [15:0] x, input logic [15:0] y);
    v[r] = 1'b1;
    s[r] = sel;
    a[r] = x;
    b[r] = y;
  endtask

  task automatic chk_rst(input string p);
    chk({p, "_res"},  o_result, 32'd0);
    chk({p, "_zero"}, o_zero, 1);
    chk({p, "_err"},  o_err, 0);
    chk({p, "_id"},   o_resp_id, 0);
    chk({p, "_rv"},   o_resp_valid, 0);
    chk({p, "_busy"}, o_busy, 0);
    chk({p, "_rdy0"}, o_ready0, 0);
    chk({p, "_rdy1"}, o_ready1, 0);
  endtask

  task automatic do_reset(input int n);
    i_rst = 1'b1;
    repeat (n) begin
      @(posedge i_clk);
      #2;
    end
    ptr  = 0;
    last = 32'd0;
    #1;
    chk_rst("rst");
    i_rst = 1'b0;
  endtask

  // One full transaction from IDLE; hold = cycles of back-pressure in RESP.
  task automatic txn(input int hold);
    int          w;
    logic [32:0] e;
    w = (v[0] && v[1]) ? ptr : (v[0] ? 0 : 1);
    e = ref_op(s[w], a[w], b[w], last);
    i_resp_ready = 1'b0;
    #1;
    chk("idle_busy", o_busy, 0);
    chk("idle_rv",   o_resp_valid, 0);
    chk("gnt0",      o_ready0, w == 0);
    chk("gnt1",      o_ready1, w == 1);
    @(posedge i_clk);
    #2;
    v[w] = 1'b0;
    ptr  = 1 - w;
    last = e[31:0];
    #1;
    chk("exec_rv",   o_resp_valid, 0);
    chk("exec_busy", o_busy, 1);
    chk("exec_rdy0", o_ready0, 0);
    chk("exec_rdy1", o_ready1, 0);
    @(posedge i_clk);
    #2;
    for (int k = 0; k <= hold; k++) begin
      i_resp_ready = (k == hold);
      #1;
      chk("resp_rv",   o_resp_valid, 1);
      chk("resp_res",  o_result, e[31:0]);
      chk("resp_zero", o_zero, e[31:0] == 32'd0);
      chk("resp_err",  o_err, e[32]);
      chk("resp_id",   o_resp_id, w);
      chk("resp_busy", o_busy, 1);
      chk("resp_rdy0", o_ready0, 0);
      chk("resp_rdy1", o_ready1, 0);
      @(posedge i_clk);
      #2;
    end
    i_resp_ready = 1'b0;
  endtask

  initial begin
    i_rst        = 1'b1;
    i_resp_ready = 1'b0;
    for (int r = 0; r < 2; r++) begin
      v[r] = 1'b0;
      a[r] = 16'd0;
      b[r] = 16'd0;
      s[r] = 3'd4;
    end
    do_reset(2);

    // add 10+22 from req0
    req(0, 3'd0, 16'd10, 16'd22);
    txn(0);
    // req1: 20-20 then 20-22
    req(1, 3'd1, 16'd20, 16'd20);
    txn(0);
    req(1, 3'd1, 16'd20, 16'd22);
    txn(1);

    // round robin from a fresh pointer
    do_reset(1);
    req(0, 3'd2, 16'd100, 16'd125);
    req(1, 3'd3, 16'd90, 16'd30);
    txn(0);
    txn(0);
    req(0, 3'd0, 16'd1, 16'd1);
    req(1, 3'd0, 16'd2, 16'd2);
    txn(0);
    txn(0);

    // long back-pressure with the other requester waiting
    req(0, 3'd0, 16'hFFFF, 16'hFFFF);
    req(1, 3'd1, 16'd0, 16'd1);
    txn(5);
    txn(0);

    // add, nop, illegal
    req(0, 3'd0, 16'd34, 16'd45);
    txn(0);
    req(0, 3'd4, 16'd7, 16'd8);
    txn(0);
    req(1, 3'b110, 16'd3, 16'd4);
    txn(2);

    // reset while in EXEC abandons the operation
    req(0, 3'd0, 16'd1, 16'd2);
    #1;
    chk("r_exec_gnt", o_ready0, 1);
    @(posedge i_clk);
    #2;
    v[0]         = 1'b0;
    i_rst        = 1'b1;
    i_resp_ready = 1'b1;
    req(1, 3'd0, 16'd5, 16'd5);
    @(posedge i_clk);
    #3;
    chk_rst("r_exec");
    chk("r_hold_rdy1", o_ready1, 0);
    @(posedge i_clk);
    #2;
    i_rst = 1'b0;
    v[1]  = 1'b0;
    ptr   = 0;
    last  = 32'd0;
    repeat (3) begin
      #1;
      chk("r_norv", o_resp_valid, 0);
      chk("r_nobusy", o_busy, 0);
      @(posedge i_clk);
      #2;
    end
    i_resp_ready = 1'b0;

    // random traffic
    for (int t = 0; t < 80; t++) begin
      for (int r = 0; r < 2; r++) begin
        if (!v[r] && $urandom_range(0, 2) != 0) begin
          logic [15:0] x;
          logic [15:0] y;
          x = 16'($urandom);
          y = ($urandom_range(0, 4) == 0) ? x : 16'($urandom);
          req(r, 3'($urandom_range(0, 7)), x, y);
        end
      end
      if (!v[0] && !v[1]) begin
        req(int'($urandom_range(0, 1)), 3'($urandom_range(0, 3)),
            16'($urandom), 16'($urandom));
      end
      txn(int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL run on one clock; reset is synchronous and active-high.
REQ-002 SHALL have ports (name  direction  width  meaning):
- i_clk  in  1  sole clock, rising edge
- i_rst  in  1  synchronous active-high reset
- i_valid0 / i_valid1  in  1  requester 0/1 has an operation pending
- i_op1_0, i_op2_0 / i_op1_1, i_op2_1  in  16  operands per requester
- i_sel0 / i_sel1  in  3  opcode per requester: 000 add, 001 sub, 010 and, 011 or, 100 nop, 101-111 illegal
- o_ready0 / o_ready1  out  1  one-cycle grant pulse; operands captured this cycle
- o_resp_valid  out  1  response available
- i_resp_ready  in  1  consumer accepts response
- o_resp_id  out  1  requester that owns the response
- o_result  out  32  operation result
- o_zero  out  1  o_result == 0
- o_err  out  1  response came from an illegal opcode
- o_busy  out  1  state != IDLE
REQ-003 SHALL share one ALU datapath (16-bit operands, 32-bit result, ops per REQ-002) between the two requesters.

Function
REQ-004 SHALL implement FSM states IDLE, EXEC, RESP.
REQ-005 IDLE: if any i_valid high, grant exactly one requester (o_ready pulse of 1 cycle), register operands, opcode, and id, go to EXEC; else stay.
REQ-006 Arbitration: round-robin; a 1-bit priority pointer selects the winner when both are valid; pointer resets to 0 and, on each grant, moves to the non-granted requester.
REQ-007 A single valid requester SHALL be granted regardless of pointer.
REQ-008 EXEC: compute on registered operands, load result register, zero flag, err flag; go to RESP next cycle (unconditional).
REQ-009 RESP: o_resp_valid=1, o_result/o_zero/o_err/o_resp_id stable; leave to IDLE on the cycle i_resp_ready=1; hold indefinitely otherwise.
REQ-010 Latency: grant in cycle N -> o_resp_valid high in cycle N+2; min spacing between grants 3 cycles.
REQ-011 Arithmetic: operands zero-extended to 32 bits; add = op1+op2 (carry in bit 16); sub = op1-op2 modulo 2^32 (20-22 -> 32'hFFFF_FFFE); and/or bitwise, upper 16 bits 0.
REQ-012 NOP (100): result register holds previous value; o_zero recomputed from held value; o_err=0.
REQ-013 Illegal (101-111): treated as NOP for result; o_err=1 for that response.
REQ-014 o_ready SHALL never assert outside IDLE; both o_ready never high together.
REQ-015 Requesters not granted SHALL keep i_valid and inputs stable until granted; the block imposes no timeout.
REQ-016 o_resp_valid SHALL be 0 in IDLE and EXEC.

Reset
REQ-017 i_rst=1 SHALL force IDLE, pointer=0, o_result=0, o_zero=1, o_err=0, o_resp_id=0, o_resp_valid=0, o_ready0/1=0, o_busy=0, next edge.
REQ-018 Reset in EXEC or RESP SHALL abandon the in-flight operation; no response is produced for it.
REQ-019 Reset takes priority over every other input, including i_valid and i_resp_ready in the same cycle.

Verification
REQ-020 Req0 add 10+22, i_resp_ready=1 -> o_ready0 cycle N, cycle N+2 o_resp_valid=1, o_result=32, o_zero=0, o_resp_id=0.
REQ-021 Req1 sub 20-20 -> o_result=0, o_zero=1, o_resp_id=1; then sub 20-22 -> o_result=32'hFFFF_FFFE, o_zero=0.
REQ-022 Both valid after reset (req0 and 100&125, req1 or 90|30), held -> req0 granted first (result 100), req1 next (result 94); repeat both valid -> req0 granted again.
REQ-023 i_resp_ready=0 for 5 cycles in RESP -> o_resp_valid and o_result stable, no o_ready pulse, o_busy=1; release -> IDLE next cycle.
REQ-024 Add 34+45 then nop, then sel 3'b110 -> nop result 79, o_err=0; illegal result 79, o_err=1.
REQ-025 Reset asserted during EXEC -> next cycle all outputs at REQ-017 values, no response emitted.
